// File: rtl/flt2int_pkg.sv
// Shared types for the sequential float-to-int converter.
package flt2int_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CLASSIFY = 3'd1,
    SHIFT    = 3'd2,
    ROUND    = 3'd3,
    DONE     = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    RND_TRUNC = 2'd0,
    RND_RNE   = 2'd1,
    RND_RHA   = 2'd2
  } rnd_t;

  // Map the raw 2-bit mode input; the unused code 3 behaves as truncate.
  function automatic rnd_t rnd_decode(input logic [1:0] raw);
    rnd_t m;
    case (raw)
      2'd1:    m = RND_RNE;
      2'd2:    m = RND_RHA;
      default: m = RND_TRUNC;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/flt2int_seq_if.sv
// Start/done coprocessor bus of the float-to-int converter.
interface flt2int_seq_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) ();
  logic                   start;
  logic [1:0]             rnd_mode;
  logic [EXP_W+MAN_W:0]   flt_in;
  logic                   busy;
  logic                   done;
  logic [INT_W-1:0]       int_out;
  logic                   ovf;
  logic                   inexact;

  modport master (output start, rnd_mode, flt_in,
                  input  busy, done, int_out, ovf, inexact);
  modport slave  (input  start, rnd_mode, flt_in,
                  output busy, done, int_out, ovf, inexact);
endinterface

// File: rtl/flt2int_round.sv
// Combinational rounding, range check and sign application.
module flt2int_round
  import flt2int_pkg::*;
#(
  parameter int INT_W = 16,
  parameter int MAG_W = 16
) (
  input  logic [MAG_W-1:0] mag,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sign,
  input  rnd_t             mode,
  output logic [INT_W-1:0] result,
  output logic             ovf,
  output logic             inexact
);
  localparam int SW = MAG_W + 1;

  logic          inc_s;
  logic [SW-1:0] sum_s;
  logic [SW-1:0] limit_s;
  logic [INT_W-1:0] low_s;

  // Rounding increment, wide sum and saturation against the sign's range.
  always_comb begin
    case (mode)
      RND_RNE: inc_s = guard & (sticky | mag[0]);
      RND_RHA: inc_s = guard;
      default: inc_s = 1'b0;
    endcase
    sum_s   = {1'b0, mag} + SW'(inc_s);
    limit_s = (SW'(1) << (INT_W - 1)) - SW'(!sign);
    low_s   = sum_s[INT_W-1:0];
    inexact = guard | sticky;
    if (sum_s > limit_s) begin
      ovf    = 1'b1;
      result = sign ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    end else begin
      ovf    = 1'b0;
      result = sign ? (~low_s + INT_W'(1)) : low_s;
    end
  end
endmodule

// File: rtl/flt2int_seq.sv
// Sequential float-to-signed-integer converter, one shift bit per cycle.
module flt2int_seq
  import flt2int_pkg::*;
#(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int INT_W = 16
) (
  input logic          clk,
  input logic          reset,
  flt2int_seq_if.slave bus
);
  localparam int BIAS  = 2**(EXP_W-1) - 1;
  localparam int MAG_W = (INT_W > MAN_W + 1) ? INT_W : MAN_W + 1;
  localparam int CNT_W = $clog2(INT_W + MAN_W + 1);
  localparam int E_W   = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 2;

  localparam logic signed [E_W-1:0] BIAS_S  = E_W'(BIAS);
  localparam logic signed [E_W-1:0] INTW_S  = E_W'(INT_W);
  localparam logic signed [E_W-1:0] INTW1_S = E_W'(INT_W - 1);
  localparam logic signed [E_W-1:0] MANW_S  = E_W'(MAN_W);
  localparam logic signed [E_W-1:0] M1_S    = E_W'(-1);
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  state_t             state_r;
  logic               sign_r;
  logic [EXP_W-1:0]   exp_r;
  logic [MAN_W-1:0]   frac_r;
  rnd_t               mode_r;
  logic [MAG_W-1:0]   mag_r;
  logic               guard_r, sticky_r, left_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               spec_r, spec_ovf_r;
  logic [INT_W-1:0]   spec_res_r;
  logic               busy_r, done_r, ovf_r, inexact_r;
  logic [INT_W-1:0]   int_r;

  logic signed [E_W-1:0] e_s, diff_s, ndiff_s;
  logic [CNT_W-1:0]      lcnt_s, rcnt_s;
  logic [MAG_W-1:0]      mag_init_s;
  logic [INT_W-1:0]      sat_s, rnd_res_s;
  logic                  rnd_ovf_s, rnd_inx_s;

  assign e_s        = signed'({2'b00, exp_r}) - BIAS_S;
  assign diff_s     = e_s - MANW_S;
  assign ndiff_s    = MANW_S - e_s;
  assign lcnt_s     = diff_s[CNT_W-1:0];
  assign rcnt_s     = ndiff_s[CNT_W-1:0];
  assign mag_init_s = MAG_W'({(exp_r != '0), frac_r});
  assign sat_s      = sign_r ? INT_MIN : INT_MAX;

  flt2int_round #(.INT_W(INT_W), .MAG_W(MAG_W)) u_round (
    .mag     (mag_r),
    .guard   (guard_r),
    .sticky  (sticky_r),
    .sign    (sign_r),
    .mode    (mode_r),
    .result  (rnd_res_s),
    .ovf     (rnd_ovf_s),
    .inexact (rnd_inx_s)
  );

  // Control FSM with operand latch, shifter and registered outputs.
  // Special results still pass through ROUND so every short path takes the same latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      sign_r     <= 1'b0;
      exp_r      <= '0;
      frac_r     <= '0;
      mode_r     <= RND_TRUNC;
      mag_r      <= '0;
      guard_r    <= 1'b0;
      sticky_r   <= 1'b0;
      left_r     <= 1'b0;
      cnt_r      <= '0;
      spec_r     <= 1'b0;
      spec_ovf_r <= 1'b0;
      spec_res_r <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      inexact_r  <= 1'b0;
      int_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            sign_r  <= bus.flt_in[EXP_W+MAN_W];
            exp_r   <= bus.flt_in[EXP_W+MAN_W-1:MAN_W];
            frac_r  <= bus.flt_in[MAN_W-1:0];
            mode_r  <= rnd_decode(bus.rnd_mode);
            busy_r  <= 1'b1;
            state_r <= CLASSIFY;
          end
        end
        CLASSIFY: begin
          spec_r     <= 1'b0;
          spec_ovf_r <= 1'b1;
          spec_res_r <= sat_s;
          guard_r    <= 1'b0;
          sticky_r   <= 1'b0;
          mag_r      <= mag_init_s;
          if (exp_r == '1) begin
            spec_r     <= 1'b1;
            spec_res_r <= (frac_r != '0) ? INT_MAX : sat_s;
            state_r    <= ROUND;
          end else if (e_s >= INTW_S) begin
            spec_r  <= 1'b1;
            state_r <= ROUND;
          end else if (e_s == INTW1_S) begin
            spec_r <= 1'b1;
            if (sign_r && (frac_r == '0)) begin
              spec_res_r <= INT_MIN;
              spec_ovf_r <= 1'b0;
            end
            state_r <= ROUND;
          end else if ((exp_r == '0) || (e_s < M1_S)) begin
            mag_r    <= '0;
            sticky_r <= |{exp_r, frac_r};
            state_r  <= ROUND;
          end else if (e_s >= MANW_S) begin
            left_r  <= 1'b1;
            cnt_r   <= lcnt_s;
            state_r <= (lcnt_s == '0) ? ROUND : SHIFT;
          end else begin
            left_r  <= 1'b0;
            cnt_r   <= rcnt_s;
            state_r <= (rcnt_s == '0) ? ROUND : SHIFT;
          end
        end
        SHIFT: begin
          if (left_r) begin
            mag_r <= mag_r << 1;
          end else begin
            mag_r    <= mag_r >> 1;
            guard_r  <= mag_r[0];
            sticky_r <= sticky_r | guard_r;
          end
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r <= CNT_W'(1)) begin
            state_r <= ROUND;
          end
        end
        ROUND: begin
          if (spec_r) begin
            int_r     <= spec_res_r;
            ovf_r     <= spec_ovf_r;
            inexact_r <= 1'b0;
          end else begin
            int_r     <= rnd_res_s;
            ovf_r     <= rnd_ovf_s;
            inexact_r <= rnd_inx_s;
          end
          state_r <= DONE;
        end
        DONE: begin
          done_r  <= 1'b1;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.int_out = int_r;
  assign bus.ovf     = ovf_r;
  assign bus.inexact = inexact_r;
endmodule

// File: tb/tb_flt2int_seq.sv
// Directed self-checking bench for flt2int_seq (EXP_W=5, MAN_W=10, INT_W=16).
module tb_flt2int_seq;
  logic clk;
  logic reset;
  int   chk_cnt;
  int   pass_cnt;

  flt2int_seq_if #(.EXP_W(5), .MAN_W(10), .INT_W(16)) bus ();

  flt2int_seq #(.EXP_W(5), .MAN_W(10), .INT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One conversion: accept, scramble inputs, pulse an ignored start, wait for done.
  task automatic run(input logic [15:0] flt, input logic [1:0] mode,
                     input logic [15:0] exp_int, input logic exp_ovf,
                     input logic exp_inx, input int exp_lat);
    int lat;
    logic got;
    @(negedge clk);
    bus.flt_in   = flt;
    bus.rnd_mode = mode;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.flt_in   = ~flt;
    bus.rnd_mode = 2'($urandom_range(3, 0));
    chk($sformatf("busy_%h", flt), {31'd0, bus.busy}, 32'd1);
    lat = 0;
    got = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      bus.start = (k == 1);
      if (bus.done) begin
        lat = k;
        got = 1'b1;
        break;
      end
    end
    bus.start = 1'b0;
    chk($sformatf("done_seen_%h_m%0d", flt, mode), {31'd0, got}, 32'd1);
    chk($sformatf("lat_%h_m%0d", flt, mode), lat, exp_lat);
    chk($sformatf("int_%h_m%0d", flt, mode), {16'd0, bus.int_out}, {16'd0, exp_int});
    chk($sformatf("ovf_%h_m%0d", flt, mode), {31'd0, bus.ovf}, {31'd0, exp_ovf});
    chk($sformatf("inx_%h_m%0d", flt, mode), {31'd0, bus.inexact}, {31'd0, exp_inx});
    @(posedge clk);
    #1;
    chk($sformatf("done_pulse_%h", flt), {31'd0, bus.done}, 32'd0);
    chk($sformatf("hold_%h", flt), {16'd0, bus.int_out}, {16'd0, exp_int});
  endtask

  initial begin
    int dcount;
    chk_cnt      = 0;
    pass_cnt     = 0;
    bus.start    = 1'b0;
    bus.rnd_mode = 2'd0;
    bus.flt_in   = 16'h0000;
    reset        = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_int", {16'd0, bus.int_out}, 32'd0);
    chk("rst_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("rst_inx", {31'd0, bus.inexact}, 32'd0);
    reset = 1'b1;

    //   flt       mode  int       ovf   inx   latency
    run(16'h3C00, 2'd0, 16'h0001, 1'b0, 1'b0, 13);
    run(16'h4100, 2'd0, 16'h0002, 1'b0, 1'b1, 12);
    run(16'h4100, 2'd1, 16'h0002, 1'b0, 1'b1, 12);
    run(16'h4100, 2'd2, 16'h0003, 1'b0, 1'b1, 12);
    run(16'h4100, 2'd3, 16'h0002, 1'b0, 1'b1, 12);
    run(16'h4300, 2'd1, 16'h0004, 1'b0, 1'b1, 12);
    run(16'hC100, 2'd2, 16'hFFFD, 1'b0, 1'b1, 12);
    run(16'h3800, 2'd1, 16'h0000, 1'b0, 1'b1, 14);
    run(16'h3800, 2'd2, 16'h0001, 1'b0, 1'b1, 14);
    run(16'h4A00, 2'd0, 16'h000C, 1'b0, 1'b0, 10);
    run(16'h7400, 2'd0, 16'h4000, 1'b0, 1'b0, 7);
    run(16'hF3FF, 2'd0, 16'hC008, 1'b0, 1'b0, 6);
    run(16'hF800, 2'd0, 16'h8000, 1'b0, 1'b0, 3);
    run(16'h7800, 2'd0, 16'h7FFF, 1'b1, 1'b0, 3);
    run(16'h7C00, 2'd0, 16'h7FFF, 1'b1, 1'b0, 3);
    run(16'hFC00, 2'd0, 16'h8000, 1'b1, 1'b0, 3);
    run(16'h7E00, 2'd0, 16'h7FFF, 1'b1, 1'b0, 3);
    run(16'h0001, 2'd0, 16'h0000, 1'b0, 1'b1, 3);
    run(16'h3400, 2'd2, 16'h0000, 1'b0, 1'b1, 3);
    run(16'h8000, 2'd0, 16'h0000, 1'b0, 1'b0, 3);

    // Leave ovf=1 visible, then abort a long conversion mid-shift.
    run(16'h7C00, 2'd0, 16'h7FFF, 1'b1, 1'b0, 3);
    @(negedge clk);
    bus.flt_in = 16'h3C00;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort_int", {16'd0, bus.int_out}, 32'd0);
    chk("abort_ovf", {31'd0, bus.ovf}, 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    reset  = 1'b1;
    dcount = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run(16'h4300, 2'd1, 16'h0004, 1'b0, 1'b1, 12);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
